fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage plus IF/ID pipeline register of the pipelined RV32I core.
//   Owns the program counter and drives the instruction-memory address.
//   Registers the fetched word into InstrD, which feeds the decoder and the immediate extender.
//   Handles stall, flush and branch/jump redirect under hazard-unit control.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PCF value loaded on reset
//   NOP_INSTR  32'h0000_0013  bubble word (addi x0,x0,0) placed in InstrD on reset/flush
// PORTS
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-high reset
//   StallF       in   1   hold PCF
//   StallD       in   1   hold IF/ID register
//   FlushD       in   1   replace IF/ID contents with bubble
//   PCSrcE       in   1   taken branch/jump resolved in Execute; redirect PC
//   PCTargetE    in   32  redirect target from Execute
//   InstrF       in   32  instruction-memory read data for address PCF (combinational read)
//   PCF          out  32  current fetch PC; drives instruction-memory address
//   InstrD       out  32  registered instruction to Decode
//   PCD          out  32  PC of InstrD
//   PCPlus4D     out  32  PCD + 4
//   ValidD       out  1   1 = InstrD is a real fetched instruction, 0 = bubble
//   MisalignErr  out  1   sticky: a redirect target had PCTargetE[1:0] != 2'b00
// BEHAVIOUR
//   Reset (sync, highest priority): PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0,
//     ValidD=0, MisalignErr=0. Reset asserted mid-operation discards all state on that edge.
//   PCPlus4F = PCF + 32'd4, modulo 2^32 (32'hFFFF_FFFC wraps to 0; no flag raised).
//   PC next-state priority (per edge, reset excluded):
//     1. PCSrcE=1: PCF <= {PCTargetE[31:2],2'b00}; this overrides StallF.
//     2. StallF=1: PCF holds.
//     3. Otherwise: PCF <= PCPlus4F.
//   MisalignErr: set on any edge where PCSrcE=1 and PCTargetE[1:0]!=0. Cleared only by reset.
//   IF/ID register priority (per edge, reset excluded):
//     1. FlushD=1: InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0. Flush overrides StallD.
//     2. StallD=1: all D outputs hold.
//     3. Otherwise: InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=1.
//   Latency: the word at address PCF appears on InstrD one edge later.
//     There are no combinational paths from inputs to any D-stage output.
//     PCF is a pure register output.
//   Hazard-unit contract:
//     Load-use stall: StallF=StallD=1 for one cycle.
//     Taken branch: PCSrcE=1 together with FlushD=1.
//     The block does not self-flush on PCSrcE; the two signals are independent inputs.
//   Bubble state: ValidD=0 marks a bubble.
//     Downstream stages must not commit any state when ValidD=0.
//     NOP_INSTR keeps decode outputs benign even without gating.
// TESTING
//   1. Reset, then 4 free-running cycles with InstrF=mem[PCF>>2].
//      Required: PCF=0,4,8,C,10; InstrD follows one cycle behind; ValidD=1 after the first edge.
//   2. PCF=8 with StallF=StallD=1 for 1 cycle.
//      Required: PCF stays 8; InstrD/PCD hold 4's word and PC; sequence resumes 0xC next cycle.
//   3. PCF=0x10 with PCSrcE=1, PCTargetE=0x40, FlushD=1.
//      Required: next cycle PCF=0x40, InstrD=0x00000013, ValidD=0; then PCD=0x40.
//   4. StallF=1 and PCSrcE=1 (target 0x80) on the same edge.
//      Required: PCF=0x80. FlushD=1 with StallD=1: required bubble (ValidD=0).
//   5. PCSrcE=1, PCTargetE=0x22.
//      Required: PCF=0x20 and MisalignErr=1, held until reset; reset with PCF=0x100 gives PCF=0.
//   6. Load PCF=0xFFFF_FFFC via redirect, then one free cycle.
//      Required: PCF=0x0, PCPlus4D=0x0 paired with PCD=0xFFFF_FFFC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Owns the PC; stall, flush and redirect come from the hazard unit.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        MisalignErr
);

    logic [31:0] pcplus4f;
    logic [31:0] pcnext;

    assign pcplus4f = PCF + 32'd4;

    // A redirect wins over a fetch stall; low bits are forced to word alignment.
    always_comb begin
        pcnext = pcplus4f;
        if (PCSrcE)
            pcnext = {PCTargetE[31:2], 2'b00};
        else if (StallF)
            pcnext = PCF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PCF         <= RESET_PC;
            MisalignErr <= 1'b0;
        end else begin
            PCF <= pcnext;
            if (PCSrcE && (PCTargetE[1:0] != 2'b00))
                MisalignErr <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= pcplus4f;
            ValidD   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage.
// Expected D/F state is queued per edge and compared after it.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        MisalignErr;

    int checks;
    int failures;

    typedef struct packed {
        logic [31:0] pcf;
        logic [31:0] instrd;
        logic [31:0] pcd;
        logic [31:0] p4d;
        logic        validd;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_p4d;
    logic        m_valid;
    logic        m_mis;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .InstrF     (InstrF),
        .PCF        (PCF),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .MisalignErr(MisalignErr)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
    endfunction

    assign InstrF = memf(PCF);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic sf,
                        input logic sd, input logic fd,
                        input logic br, input logic [31:0] tgt);
        exp_t e;
        exp_t o;
        logic [31:0] p4;
        reset = rst; StallF = sf; StallD = sd;
        FlushD = fd; PCSrcE = br; PCTargetE = tgt;
        p4 = m_pc + 32'd4;
        if (rst) begin
            m_mis = 1'b0;
            m_instr = 32'h13; m_pcd = 0; m_p4d = 0; m_valid = 0;
            m_pc = 32'd0;
        end else begin
            if (br && tgt[1:0] != 2'b00) m_mis = 1'b1;
            if (fd) begin
                m_instr = 32'h13; m_pcd = 0; m_p4d = 0; m_valid = 0;
            end else if (!sd) begin
                m_instr = memf(m_pc); m_pcd = m_pc;
                m_p4d = p4; m_valid = 1'b1;
            end
            if (br) m_pc = {tgt[31:2], 2'b00};
            else if (!sf) m_pc = p4;
        end
        e.pcf = m_pc; e.instrd = m_instr; e.pcd = m_pcd;
        e.p4d = m_p4d; e.validd = m_valid; e.mis = m_mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            o = sb.pop_front();
            chk("PCF", PCF, o.pcf);
            chk("InstrD", InstrD, o.instrd);
            chk("PCD", PCD, o.pcd);
            chk("PCPlus4D", PCPlus4D, o.p4d);
            chk("ValidD", {31'd0, ValidD}, {31'd0, o.validd});
            chk("MisalignErr", {31'd0, MisalignErr}, {31'd0, o.mis});
        end
        reset = 0; StallF = 0; StallD = 0;
        FlushD = 0; PCSrcE = 0; PCTargetE = 0;
    endtask

    task automatic free(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        m_pc = 0; m_instr = 0; m_pcd = 0;
        m_p4d = 0; m_valid = 0; m_mis = 0;
        reset = 1; StallF = 0; StallD = 0;
        FlushD = 0; PCSrcE = 0; PCTargetE = 0;

        // 1: reset and free run
        step(1, 0, 0, 0, 0, 32'd0);
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_instr", InstrD, 32'h13);
        chk("rst_valid", {31'd0, ValidD}, 32'd0);
        free(4);
        chk("t1_pcf", PCF, 32'h10);
        chk("t1_pcd", PCD, 32'hC);
        chk("t1_instr", InstrD, memf(32'hC));

        // 2: load-use stall at PCF=8
        step(1, 0, 0, 0, 0, 32'd0);
        free(2);
        step(0, 1, 1, 0, 0, 32'd0);
        chk("t2_pcf", PCF, 32'h8);
        chk("t2_pcd", PCD, 32'h4);
        free(1);
        chk("t2_resume", PCF, 32'hC);

        // 3: taken branch with flush
        step(1, 0, 0, 0, 0, 32'd0);
        free(4);
        step(0, 0, 0, 1, 1, 32'h40);
        chk("t3_pcf", PCF, 32'h40);
        chk("t3_bubble", InstrD, 32'h13);
        chk("t3_valid", {31'd0, ValidD}, 32'd0);
        free(1);
        chk("t3_pcd", PCD, 32'h40);

        // 4: redirect beats stall; flush beats stall
        step(0, 1, 0, 0, 1, 32'h80);
        chk("t4_pcf", PCF, 32'h80);
        step(0, 0, 1, 1, 0, 32'd0);
        chk("t4_valid", {31'd0, ValidD}, 32'd0);

        // 5: misaligned target, sticky until reset
        step(0, 0, 0, 0, 1, 32'h22);
        chk("t5_pcf", PCF, 32'h20);
        chk("t5_mis", {31'd0, MisalignErr}, 32'd1);
        free(3);
        step(0, 0, 0, 0, 1, 32'h100);
        chk("t5_hold", {31'd0, MisalignErr}, 32'd1);
        step(1, 0, 0, 0, 0, 32'd0);
        chk("t5_rst_pc", PCF, 32'h0);

        // 6: PC wraparound
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        free(1);
        chk("t6_pcf", PCF, 32'h0);
        chk("t6_pcd", PCD, 32'hFFFF_FFFC);
        chk("t6_p4d", PCPlus4D, 32'h0);

        // mixed random traffic
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0),
                 $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
